// File: rtl/cpu_run_ctrl_pkg.sv
// Shared encodings and defaults for the host-facing run controller of the 8-bit accumulator core.
package cpu_run_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'd0,
    OP_BYTE  = 3'd1,
    OP_RUN   = 3'd2,
    OP_STEP  = 3'd3,
    OP_STOP  = 3'd4,
    OP_CLEAR = 3'd5,
    OP_BKPT  = 3'd6,
    OP_RSVD  = 3'd7
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_STEP   = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  localparam int ADDR_W_DEF    = 5;
  localparam int MEM_DEPTH_DEF = 25;
  localparam int STEP_CYC_DEF  = 3;
  localparam int WDOG_MAX_DEF  = 1023;

  // A program length is usable only if non-empty and it fits the instruction memory.
  function automatic logic len_ok(input logic [4:0] len, input int depth);
    return (len != 5'd0) && (int'(len) <= depth);
  endfunction

endpackage

// File: rtl/run_wdog.sv
// Loadable down-counter with enable and zero flag; times both the STEP window and the RUN watchdog.
module run_wdog #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (en_i && (cnt_q != '0))
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Program loader and run/step/stop gate for the accumulator core.
// Optional breakpoint command enabled by defining CPU_RUN_CTRL_BKPT_EN.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int STEP_CYC  = STEP_CYC_DEF,
  parameter int WDOG_MAX  = WDOG_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic [2:0]        cmd_op,
  input  logic [7:0]        cmd_data,
  output logic              cmd_ready,
  output logic              core_we,
  output logic [ADDR_W-1:0] core_waddr,
  output logic [7:0]        core_wdata,
  output logic              core_run_en,
  input  logic              core_halted,
  input  logic [ADDR_W-1:0] core_pc,
  output logic [2:0]        state_o,
  output logic [ADDR_W-1:0] prog_len,
  output logic              err
);

  localparam int CNT_MAX = (WDOG_MAX > STEP_CYC) ? WDOG_MAX : STEP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] STEP_LD = CNT_W'(STEP_CYC - 1);
  localparam logic [CNT_W-1:0] WDOG_LD = CNT_W'((WDOG_MAX == 0) ? 0 : WDOG_MAX - 1);
  localparam bit WDOG_ON = (WDOG_MAX != 0);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              run_en_q, run_en_d;
  logic [ADDR_W-1:0] prog_len_q, prog_len_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] ld_cnt_q, ld_cnt_d;

  cmd_op_e          op;
  logic             ready, acc;
  logic             cnt_load, cnt_en, cnt_zero;
  logic [CNT_W-1:0] cnt_ld_val;

`ifdef CPU_RUN_CTRL_BKPT_EN
  logic              bkpt_arm_q, bkpt_arm_d;
  logic [ADDR_W-1:0] bkpt_addr_q, bkpt_addr_d;
`else
  logic unused_pc;
  assign unused_pc = ^core_pc;
`endif

  assign op  = cmd_op_e'(cmd_op);
  assign acc = cmd_valid & ready;

  // RUN only listens for STOP/CLEAR; HALTED only for CLEAR; a STEP window ignores the host.
  always_comb begin
    ready = 1'b0;
    case (state_q)
      ST_IDLE, ST_LOAD: ready = 1'b1;
      ST_RUN:           ready = (op == OP_STOP) || (op == OP_CLEAR);
      ST_HALTED:        ready = (op == OP_CLEAR);
      default:          ready = 1'b0;
    endcase
  end

  run_wdog #(.CNT_W(CNT_W)) u_wdog (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .en_i       (cnt_en),
    .load_val_i (cnt_ld_val),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    prog_len_d = prog_len_q;
    err_d      = err_q;
    ld_cnt_d   = ld_cnt_q;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    cnt_ld_val = STEP_LD;
`ifdef CPU_RUN_CTRL_BKPT_EN
    bkpt_arm_d  = bkpt_arm_q;
    bkpt_addr_d = bkpt_addr_q;
`endif

    // CLEAR is an error during LOAD, so it only clears outside that state.
    if (acc && (op == OP_CLEAR) && (state_q != ST_LOAD))
      err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (acc) begin
          case (op)
            OP_LOAD: begin
              if (len_ok(cmd_data[4:0], MEM_DEPTH)) begin
                state_d    = ST_LOAD;
                ld_cnt_d   = '0;
                prog_len_d = ADDR_W'(cmd_data[4:0]);
              end else begin
                err_d = 1'b1;
              end
            end
            OP_RUN: begin
              state_d    = ST_RUN;
              cnt_load   = 1'b1;
              cnt_ld_val = WDOG_LD;
            end
            OP_STEP: begin
              state_d    = ST_STEP;
              cnt_load   = 1'b1;
              cnt_ld_val = STEP_LD;
            end
            OP_STOP, OP_CLEAR: ;
`ifdef CPU_RUN_CTRL_BKPT_EN
            OP_BKPT: begin
              bkpt_arm_d  = 1'b1;
              bkpt_addr_d = ADDR_W'(cmd_data[4:0]);
            end
`endif
            default: err_d = 1'b1;
          endcase
        end
      end
      ST_LOAD: begin
        if (acc) begin
          if (op == OP_BYTE) begin
            we_d     = 1'b1;
            waddr_d  = ld_cnt_q;
            wdata_d  = cmd_data;
            ld_cnt_d = ld_cnt_q + ADDR_W'(1);
            if (ld_cnt_d == prog_len_q)
              state_d = ST_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_RUN: begin
        cnt_en = WDOG_ON;
        if (core_halted) begin
          state_d = ST_HALTED;
`ifdef CPU_RUN_CTRL_BKPT_EN
        end else if (bkpt_arm_q && (core_pc == bkpt_addr_q)) begin
          state_d    = ST_IDLE;
          bkpt_arm_d = 1'b0;
`endif
        end else if (acc && (op == OP_STOP)) begin
          state_d = ST_IDLE;
        end else if (WDOG_ON && cnt_zero) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_STEP: begin
        cnt_en = 1'b1;
        if (core_halted)   state_d = ST_HALTED;
        else if (cnt_zero) state_d = ST_IDLE;
      end
      ST_HALTED: begin
        if (acc) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    run_en_d = (state_d == ST_RUN) || (state_d == ST_STEP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      run_en_q   <= 1'b0;
      prog_len_q <= '0;
      err_q      <= 1'b0;
      ld_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      run_en_q   <= run_en_d;
      prog_len_q <= prog_len_d;
      err_q      <= err_d;
      ld_cnt_q   <= ld_cnt_d;
    end
  end

`ifdef CPU_RUN_CTRL_BKPT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bkpt_arm_q  <= 1'b0;
      bkpt_addr_q <= '0;
    end else begin
      bkpt_arm_q  <= bkpt_arm_d;
      bkpt_addr_q <= bkpt_addr_d;
    end
  end
`endif

  assign cmd_ready   = ready;
  assign core_we     = we_q;
  assign core_waddr  = waddr_q;
  assign core_wdata  = wdata_q;
  assign core_run_en = run_en_q;
  assign state_o     = state_q;
  assign prog_len    = prog_len_q;
  assign err         = err_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Randomized bench for cpu_run_ctrl with a cycle-level behavioural model and directed anchors.
module tb_cpu_run_ctrl;

  localparam int AW    = 5;
  localparam int DEPTH = 25;
  localparam int SCYC  = 3;
  localparam int WDOG  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [2:0]    cmd_op = 3'd0;
  logic [7:0]    cmd_data = 8'd0;
  logic          core_halted = 1'b0;
  logic [AW-1:0] core_pc = '0;
  logic          cmd_ready, core_we, core_run_en, err;
  logic [AW-1:0] core_waddr, prog_len;
  logic [7:0]    core_wdata;
  logic [2:0]    state_o;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.ADDR_W(AW), .MEM_DEPTH(DEPTH), .STEP_CYC(SCYC), .WDOG_MAX(WDOG)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .core_we(core_we), .core_waddr(core_waddr), .core_wdata(core_wdata),
    .core_run_en(core_run_en), .core_halted(core_halted), .core_pc(core_pc),
    .state_o(state_o), .prog_len(prog_len), .err(err)
  );

  int checks = 0;
  int errs   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0=IDLE 1=LOAD 2=RUN 3=STEP 4=HALTED; counts RUN cycles up and STEP cycles down.
  int            m_mode, m_plen, m_nb, m_age, m_left, m_op, m_baddr;
  bit            m_err, m_we, m_acc, m_arm;
  logic [AW-1:0] m_waddr;
  logic [7:0]    m_wdata;

  function automatic bit m_ready(input int op);
    case (m_mode)
      0, 1:    return 1'b1;
      2:       return (op == 4) || (op == 5);
      4:       return (op == 5);
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_plen = 0; m_nb = 0; m_age = 0; m_left = 0; m_err = 0; m_we = 0;
      m_waddr = '0; m_wdata = '0; m_arm = 0; m_baddr = 0;
    end else begin
      m_op  = int'(cmd_op);
      m_acc = cmd_valid && m_ready(m_op);
      m_we  = 0;
      if (m_acc && m_op == 5 && m_mode != 1) m_err = 0;
      case (m_mode)
        0: if (m_acc) begin
          case (m_op)
            0: if (cmd_data[4:0] != 0 && int'(cmd_data[4:0]) <= DEPTH) begin
                 m_mode = 1; m_plen = int'(cmd_data[4:0]); m_nb = 0;
               end else m_err = 1;
            2: begin m_mode = 2; m_age = 0; end
            3: begin m_mode = 3; m_left = SCYC; end
            4, 5: ;
`ifdef CPU_RUN_CTRL_BKPT_EN
            6: begin m_arm = 1; m_baddr = int'(cmd_data[4:0]); end
`endif
            default: m_err = 1;
          endcase
        end
        1: if (m_acc) begin
          if (m_op == 1) begin
            m_we = 1; m_waddr = AW'(m_nb); m_wdata = cmd_data; m_nb++;
            if (m_nb == m_plen) m_mode = 0;
          end else begin
            m_err = 1; m_mode = 0;
          end
        end
        2: begin
          m_age++;
          if (core_halted) m_mode = 4;
          else if (m_arm && int'(core_pc) == m_baddr) begin m_mode = 0; m_arm = 0; end
          else if (m_acc && m_op == 4) m_mode = 0;
          else if (WDOG != 0 && m_age >= WDOG) begin m_err = 1; m_mode = 0; end
        end
        3: begin
          m_left--;
          if (core_halted) m_mode = 4;
          else if (m_left == 0) m_mode = 0;
        end
        4: if (m_acc) m_mode = 0;
        default: m_mode = 0;
      endcase
    end
  end

  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("state",    32'(state_o),     32'(m_mode));
      chk("cmd_ready", 32'(cmd_ready),  32'(m_ready(int'(cmd_op))));
      chk("core_we",  32'(core_we),     32'(m_we));
      chk("waddr",    32'(core_waddr),  32'(m_waddr));
      chk("wdata",    32'(core_wdata),  32'(m_wdata));
      chk("run_en",   32'(core_run_en), 32'(m_mode == 2 || m_mode == 3));
      chk("prog_len", 32'(prog_len),    32'(m_plen));
      chk("err",      32'(err),         32'(m_err));
    end
  end

  int            run_cnt = 0;
  logic [AW-1:0] wa_q[$];
  logic [7:0]    wd_q[$];
  always @(negedge clk) begin
    if (core_run_en) run_cnt++;
    if (core_we) begin wa_q.push_back(core_waddr); wd_q.push_back(core_wdata); end
  end

  // Every task starts and ends 2 time units after a rising edge.
  task automatic cmd(input logic [2:0] op, input logic [7:0] d);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    @(posedge clk); #2;
    cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  logic [7:0] exp_d [3];
  int nw, r;

  initial begin
    exp_d = '{8'h01, 8'h2A, 8'h0A};
    @(posedge clk); #2;
    chk("rst_state", 32'(state_o), 0);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_run_en", 32'(core_run_en), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_prog_len", 32'(prog_len), 0);
    cmp_en = 1;
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Load three bytes.
    wa_q.delete(); wd_q.delete();
    cmd(3'd0, 8'd3); cmd(3'd1, 8'h01); cmd(3'd1, 8'h2A); cmd(3'd1, 8'h0A);
    idle(1);
    chk("t1_nwrites", 32'(wa_q.size()), 3);
    for (int i = 0; i < 3; i++) begin
      if (wa_q.size() > i) begin
        chk("t1_addr", 32'(wa_q[i]), 32'(i));
        chk("t1_data", 32'(wd_q[i]), 32'(exp_d[i]));
      end
    end
    chk("t1_prog_len", 32'(prog_len), 3);
    chk("t1_state", 32'(state_o), 0);

    // Free run until the core halts on its ninth cycle.
    run_cnt = 0;
    cmd(3'd2, 8'd0);
    idle(8);
    core_halted = 1'b1;
    idle(1);
    core_halted = 1'b0;
    idle(1);
    chk("t2_run_cycles", 32'(run_cnt), 9);
    chk("t2_state", 32'(state_o), 4);
    chk("t2_run_en", 32'(core_run_en), 0);
    cmd(3'd2, 8'd0);
    cmd(3'd5, 8'd0);
    idle(1);
    chk("t2_clear_state", 32'(state_o), 0);

    // Two single steps, with a held-off RUN during the window.
    for (int s = 0; s < 2; s++) begin
      run_cnt = 0;
      cmd(3'd3, 8'd0);
      cmd_valid = 1'b1; cmd_op = 3'd2; #1;
      chk("t3_ready_in_step", 32'(cmd_ready), 0);
      @(posedge clk); #2;
      cmd_valid = 1'b0;
      idle(4);
      chk("t3_step_cycles", 32'(run_cnt), 3);
      chk("t3_state", 32'(state_o), 0);
    end

    // Oversize load.
    nw = wa_q.size();
    cmd(3'd0, 8'd26);
    idle(1);
    chk("t4_err", 32'(err), 1);
    chk("t4_state", 32'(state_o), 0);
    chk("t4_no_write", 32'(wa_q.size()), 32'(nw));
    cmd(3'd5, 8'd0);
    idle(1);
    chk("t4_clear", 32'(err), 0);

    // Watchdog timeout.
    run_cnt = 0;
    cmd(3'd2, 8'd0);
    idle(20);
    chk("t5_wdog_cycles", 32'(run_cnt), 16);
    chk("t5_err", 32'(err), 1);
    chk("t5_state", 32'(state_o), 0);
    cmd(3'd5, 8'd0);

    // Asynchronous reset in the middle of a load.
    cmd(3'd0, 8'd5); cmd(3'd1, 8'h11); cmd(3'd1, 8'h22);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_state", 32'(state_o), 0);
    chk("t5_rst_we", 32'(core_we), 0);
    chk("t5_rst_waddr", 32'(core_waddr), 0);
    chk("t5_rst_wdata", 32'(core_wdata), 0);
    chk("t5_rst_prog_len", 32'(prog_len), 0);
    chk("t5_rst_ready", 32'(cmd_ready), 1);
    @(posedge clk); #2;
    rst_n = 1'b1;

`ifdef CPU_RUN_CTRL_BKPT_EN
    core_pc = '0;
    cmd(3'd6, 8'd4);
    cmd(3'd2, 8'd0);
    idle(2);
    core_pc = 5'd4;
    idle(1);
    core_pc = '0;
    chk("t6_bkpt_state", 32'(state_o), 0);
    chk("t6_bkpt_run_en", 32'(core_run_en), 0);
`else
    cmd(3'd6, 8'd4);
    idle(1);
    chk("t6_op6_err", 32'(err), 1);
    cmd(3'd5, 8'd0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 15));
      cmd_valid   = ($urandom_range(0, 1) == 1);
      cmd_op      = (r < 8) ? 3'(r) : ((r < 12) ? 3'd1 : 3'd5);
      cmd_data    = (cmd_op == 3'd0) ? 8'($urandom_range(0, 27)) : 8'($urandom);
      core_halted = ($urandom_range(0, 19) == 0);
      core_pc     = AW'($urandom);
      if (i % 997 == 500) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      @(posedge clk); #2;
    end
    cmd_valid = 1'b0; core_halted = 1'b0;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
